// File: rtl/tx_frame_packer_if.sv
// Sample-in / UART-out bundle for tx_frame_packer.
// master = sample source plus UART side; slave = the packer.
interface tx_frame_packer_if;
  logic        sample_valid;
  logic [15:0] sample;
  logic        sample_ready;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        frame_busy;
  logic        frame_done;
  logic        tx_error;
  logic [7:0]  drop_count;

  modport master (
    output sample_valid, sample, tx_busy,
    input  sample_ready, tx_start, tx_data, frame_busy, frame_done, tx_error, drop_count
  );

  modport slave (
    input  sample_valid, sample, tx_busy,
    output sample_ready, tx_start, tx_data, frame_busy, frame_done, tx_error, drop_count
  );
endinterface

// File: rtl/tx_frame_packer.sv
// Packs one 16-bit sample into a 5-byte UART frame: SYNC, SEQ, MSB, LSB, CHK.
// Each byte goes out through the UART tx_start/tx_busy handshake.
module tx_frame_packer #(
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  tx_frame_packer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_HI, S_WAIT_LO, S_NEXT
  } state_t;

  localparam int unsigned CW = $clog2(START_TIMEOUT + 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_sample;
  logic [7:0]  r_chk;
  logic [7:0]  r_seq;
  logic [7:0]  r_tx_data;
  logic [7:0]  r_drop;
  logic [2:0]  r_idx;
  logic [CW-1:0] r_cnt;
  logic        r_err;

  logic        w_accept;
  logic        w_last;
  logic        w_cnt_hit;
  logic [7:0]  w_byte;

  assign w_accept  = bus.sample_valid && (r_state == S_IDLE);
  assign w_last    = (r_idx == 3'd4);
  // Hit on the WAIT_HI cycle that brings the count up to START_TIMEOUT.
  assign w_cnt_hit = (r_cnt == CW'(START_TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (bus.sample_valid) w_next = S_LOAD;
      S_LOAD:    if (!bus.tx_busy) w_next = S_START;
      S_START:   w_next = S_WAIT_HI;
      S_WAIT_HI: begin
        if (bus.tx_busy)    w_next = S_WAIT_LO;
        else if (w_cnt_hit) w_next = S_NEXT;
      end
      S_WAIT_LO: if (!bus.tx_busy) w_next = S_NEXT;
      S_NEXT:    w_next = w_last ? S_IDLE : S_LOAD;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_byte = SYNC_BYTE;
    case (r_idx)
      3'd1:    w_byte = r_seq;
      3'd2:    w_byte = r_sample[15:8];
      3'd3:    w_byte = r_sample[7:0];
      3'd4:    w_byte = r_chk;
      default: w_byte = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sample  <= '0;
      r_chk     <= '0;
      r_seq     <= '0;
      r_tx_data <= '0;
      r_drop    <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_accept) begin
        r_sample <= bus.sample;
        r_chk    <= r_seq ^ bus.sample[15:8] ^ bus.sample[7:0];
      end

      if (bus.sample_valid && (r_state != S_IDLE) && (r_drop != 8'hFF))
        r_drop <= r_drop + 8'd1;

      if (r_state == S_LOAD)
        r_tx_data <= w_byte;

      if (r_state == S_START) begin
        r_cnt <= '0;
      end else if ((r_state == S_WAIT_HI) && !bus.tx_busy) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_cnt_hit) r_err <= 1'b1;
      end

      if (r_state == S_NEXT) begin
        if (w_last) begin
          r_idx <= '0;
          r_seq <= r_seq + 8'd1;
        end else begin
          r_idx <= r_idx + 3'd1;
        end
      end
    end
  end

  assign bus.sample_ready = (r_state == S_IDLE);
  assign bus.tx_start     = (r_state == S_START);
  assign bus.tx_data      = r_tx_data;
  assign bus.frame_busy   = (r_state != S_IDLE);
  assign bus.frame_done   = (r_state == S_NEXT) && w_last;
  assign bus.tx_error     = r_err;
  assign bus.drop_count   = r_drop;

endmodule

// File: tb/tb_tx_frame_packer.sv
// Self-checking bench for tx_frame_packer: UART model, byte capture and a frame-level reference model.
module tb_tx_frame_packer;

  logic        clk = 1'b0;
  logic        tb_reset = 1'b1;
  logic        tb_valid = 1'b0;
  logic [15:0] tb_sample = '0;
  logic        uart_busy = 1'b0;

  tx_frame_packer_if bus ();

  assign bus.sample_valid = tb_valid;
  assign bus.sample       = tb_sample;
  assign bus.tx_busy      = uart_busy;

  tx_frame_packer #(.SYNC_BYTE(8'hA5), .START_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (tb_reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] cap_q[$];
  int   done_cnt = 0;
  int   wide_cnt = 0;
  int   unstable_cnt = 0;
  bit   chk_stable = 0;
  bit   uart_en = 1;
  int   busy_len = 3;
  int   bcnt = 0;
  logic prev_start = 1'b0;
  logic prev_busy = 1'b0;
  bit   hold = 0;
  logic [7:0] hold_data = '0;
  int   m_seq = 0;

  // Monitor and UART model share one process so reads precede the busy update.
  always @(negedge clk) begin
    if (bus.tx_start === 1'b1) begin
      cap_q.push_back(bus.tx_data);
      if (prev_start === 1'b1) wide_cnt++;
    end
    prev_start = bus.tx_start;
    if (bus.frame_done === 1'b1) done_cnt++;
    if (chk_stable) begin
      if (hold && (bus.tx_data !== hold_data)) unstable_cnt++;
      if (bus.tx_start === 1'b1) begin
        hold = 1;
        hold_data = bus.tx_data;
      end else if (prev_busy && !uart_busy) begin
        hold = 0;
      end
    end
    prev_busy = uart_busy;
    if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) uart_busy = 1'b0;
    end else if ((bus.tx_start === 1'b1) && uart_en) begin
      uart_busy = 1'b1;
      bcnt = busy_len;
    end
  end

  function automatic logic [7:0] exp_byte(input int idx, input int seq, input logic [15:0] s);
    logic [7:0] sq;
    sq = 8'(seq % 256);
    case (idx)
      0:       return 8'hA5;
      1:       return sq;
      2:       return s[15:8];
      3:       return s[7:0];
      default: return sq ^ s[15:8] ^ s[7:0];
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tb_valid = 1'b0;
    tb_reset = 1'b1;
    tick();
    tick();
    tb_reset = 1'b0;
    m_seq = 0;
    cap_q.delete();
  endtask

  task automatic run_frame(input logic [15:0] s, input int limit, output bit done);
    int d0;
    d0 = done_cnt;
    cap_q.delete();
    tb_sample = s;
    tb_valid = 1'b1;
    tick();
    tb_valid = 1'b0;
    done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      tick();
      if (done_cnt != d0) done = 1;
    end
  endtask

  task automatic test_reset();
    tb_valid = 1'b0;
    tb_reset = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.sample_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b expected 1", bus.sample_ready); end
    n_checks++; if (bus.tx_start !== 1'b0) begin n_errors++; $display("FAIL reset_tx_start: got %b expected 0", bus.tx_start); end
    n_checks++; if (bus.tx_data !== 8'h00) begin n_errors++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
    n_checks++; if (bus.frame_busy !== 1'b0) begin n_errors++; $display("FAIL reset_frame_busy: got %b expected 0", bus.frame_busy); end
    n_checks++; if (bus.frame_done !== 1'b0) begin n_errors++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
    n_checks++; if (bus.tx_error !== 1'b0) begin n_errors++; $display("FAIL reset_tx_error: got %b expected 0", bus.tx_error); end
    n_checks++; if (bus.drop_count !== 8'h00) begin n_errors++; $display("FAIL reset_drop_count: got %h expected 00", bus.drop_count); end
    tb_reset = 1'b0;
    m_seq = 0;
    cap_q.delete();
    tick();
  endtask

  task automatic test_basic_frame();
    logic [15:0] s;
    int d0;
    bit done;
    s = 16'h1234;
    uart_en = 1; busy_len = 3;
    cap_q.delete();
    d0 = done_cnt;
    tb_sample = s;
    tb_valid = 1'b1;
    tick();
    tb_valid = 1'b0;
    n_checks++; if (bus.sample_ready !== 1'b0) begin n_errors++; $display("FAIL accept_ready: got %b expected 0", bus.sample_ready); end
    n_checks++; if (bus.frame_busy !== 1'b1) begin n_errors++; $display("FAIL accept_frame_busy: got %b expected 1", bus.frame_busy); end
    n_checks++; if (bus.tx_start !== 1'b0) begin n_errors++; $display("FAIL load_tx_start: got %b expected 0", bus.tx_start); end
    tick();
    n_checks++; if (bus.tx_start !== 1'b1) begin n_errors++; $display("FAIL sync_latency: tx_start got %b expected 1", bus.tx_start); end
    n_checks++; if (bus.tx_data !== 8'hA5) begin n_errors++; $display("FAIL sync_data: got %h expected a5", bus.tx_data); end
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (done_cnt != d0) done = 1;
    end
    n_checks++; if (!done) begin n_errors++; $display("FAIL basic_timeout: frame_done got 0 expected 1 within 200 cycles"); end
    n_checks++; if (cap_q.size() != 5) begin n_errors++; $display("FAIL basic_nbytes: got %0d expected 5", cap_q.size()); end
    for (int i = 0; i < 5 && i < cap_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== exp_byte(i, m_seq, s)) begin
        n_errors++; $display("FAIL basic_byte%0d: got %h expected %h", i, cap_q[i], exp_byte(i, m_seq, s));
      end
    end
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (done_cnt - d0 != 1) begin n_errors++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt - d0); end
    n_checks++; if (bus.drop_count !== 8'h00) begin n_errors++; $display("FAIL basic_drop: got %h expected 00", bus.drop_count); end
    m_seq = (m_seq + 1) % 256;
  endtask

  task automatic test_second_frame();
    logic [15:0] s;
    bit done;
    s = 16'hFFFF;
    wide_cnt = 0; unstable_cnt = 0; hold = 0; chk_stable = 1;
    run_frame(s, 200, done);
    chk_stable = 0;
    n_checks++; if (!done) begin n_errors++; $display("FAIL second_timeout: frame_done got 0 expected 1"); end
    n_checks++; if (cap_q.size() != 5) begin n_errors++; $display("FAIL second_nbytes: got %0d expected 5", cap_q.size()); end
    for (int i = 0; i < 5 && i < cap_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== exp_byte(i, m_seq, s)) begin
        n_errors++; $display("FAIL second_byte%0d: got %h expected %h", i, cap_q[i], exp_byte(i, m_seq, s));
      end
    end
    n_checks++; if (wide_cnt != 0) begin n_errors++; $display("FAIL start_width: multi-cycle starts got %0d expected 0", wide_cnt); end
    n_checks++; if (unstable_cnt != 0) begin n_errors++; $display("FAIL data_stable: changes while busy got %0d expected 0", unstable_cnt); end
    m_seq = (m_seq + 1) % 256;
    tick();
  endtask

  task automatic test_drop_saturate();
    logic [15:0] s;
    int d0;
    bit done;
    s = 16'($urandom);
    uart_en = 1; busy_len = 80;
    cap_q.delete();
    d0 = done_cnt;
    tb_sample = s;
    tb_valid = 1'b1;
    for (int i = 1; i <= 301; i++) begin
      tick();
      if (i == 101) begin
        n_checks++; if (bus.drop_count !== 8'd100) begin n_errors++; $display("FAIL drop_mid: got %0d expected 100", bus.drop_count); end
      end
    end
    tb_valid = 1'b0;
    n_checks++; if (bus.frame_busy !== 1'b1) begin n_errors++; $display("FAIL drop_still_busy: got %b expected 1", bus.frame_busy); end
    tick();
    n_checks++; if (bus.drop_count !== 8'd255) begin n_errors++; $display("FAIL drop_saturate: got %0d expected 255", bus.drop_count); end
    done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      tick();
      if (done_cnt != d0) done = 1;
    end
    n_checks++; if (!done) begin n_errors++; $display("FAIL drop_timeout: frame_done got 0 expected 1"); end
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (cap_q.size() != 5) begin n_errors++; $display("FAIL drop_one_frame: bytes got %0d expected 5", cap_q.size()); end
    for (int i = 0; i < 5 && i < cap_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== exp_byte(i, m_seq, s)) begin
        n_errors++; $display("FAIL drop_byte%0d: got %h expected %h", i, cap_q[i], exp_byte(i, m_seq, s));
      end
    end
    n_checks++; if (bus.drop_count !== 8'd255) begin n_errors++; $display("FAIL drop_hold: got %0d expected 255", bus.drop_count); end
    m_seq = (m_seq + 1) % 256;
    busy_len = 3;
  endtask

  task automatic test_start_timeout();
    logic [15:0] s;
    int d0;
    bit seen, done;
    do_reset();
    uart_en = 0;
    s = 16'($urandom);
    d0 = done_cnt;
    tb_sample = s;
    tb_valid = 1'b1;
    tick();
    tb_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (bus.tx_start === 1'b1) seen = 1;
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL tmo_first_start: got 0 expected 1 within 20 cycles"); end
    for (int i = 0; i < 15; i++) tick();
    n_checks++; if (bus.tx_error !== 1'b0) begin n_errors++; $display("FAIL tmo_early: tx_error got %b expected 0", bus.tx_error); end
    tick();
    tick();
    n_checks++; if (bus.tx_error !== 1'b1) begin n_errors++; $display("FAIL tmo_set: tx_error got %b expected 1", bus.tx_error); end
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (done_cnt != d0) done = 1;
    end
    n_checks++; if (!done) begin n_errors++; $display("FAIL tmo_timeout: frame_done got 0 expected 1"); end
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (cap_q.size() != 5) begin n_errors++; $display("FAIL tmo_starts: got %0d expected 5", cap_q.size()); end
    for (int i = 0; i < 5 && i < cap_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== exp_byte(i, m_seq, s)) begin
        n_errors++; $display("FAIL tmo_byte%0d: got %h expected %h", i, cap_q[i], exp_byte(i, m_seq, s));
      end
    end
    n_checks++; if (done_cnt - d0 != 1) begin n_errors++; $display("FAIL tmo_done_pulses: got %0d expected 1", done_cnt - d0); end
    n_checks++; if (bus.tx_error !== 1'b1) begin n_errors++; $display("FAIL tmo_sticky: got %b expected 1", bus.tx_error); end
    m_seq = (m_seq + 1) % 256;
    uart_en = 1;
  endtask

  task automatic test_mid_frame_reset();
    logic [15:0] s;
    int d0;
    bit hit, done;
    do_reset();
    uart_en = 1; busy_len = 3;
    d0 = done_cnt;
    tb_sample = 16'($urandom);
    tb_valid = 1'b1;
    tick();
    tb_valid = 1'b0;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick();
      if (cap_q.size() == 3) hit = 1;
    end
    n_checks++; if (!hit) begin n_errors++; $display("FAIL mrst_reach_msb: got 0 expected 1"); end
    tb_reset = 1'b1;
    tb_valid = 1'b1;
    tick();
    n_checks++; if (bus.sample_ready !== 1'b1) begin n_errors++; $display("FAIL mrst_ready: got %b expected 1", bus.sample_ready); end
    n_checks++; if (bus.frame_busy !== 1'b0) begin n_errors++; $display("FAIL mrst_frame_busy: got %b expected 0", bus.frame_busy); end
    n_checks++; if (bus.tx_start !== 1'b0) begin n_errors++; $display("FAIL mrst_tx_start: got %b expected 0", bus.tx_start); end
    n_checks++; if (bus.drop_count !== 8'h00) begin n_errors++; $display("FAIL mrst_drop: got %h expected 00", bus.drop_count); end
    tb_reset = 1'b0;
    tb_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_checks++; if (done_cnt != d0) begin n_errors++; $display("FAIL mrst_no_done: got %0d expected %0d", done_cnt, d0); end
    m_seq = 0;
    s = 16'h0001;
    run_frame(s, 200, done);
    n_checks++; if (!done) begin n_errors++; $display("FAIL mrst_timeout: frame_done got 0 expected 1"); end
    n_checks++; if (cap_q.size() != 5) begin n_errors++; $display("FAIL mrst_nbytes: got %0d expected 5", cap_q.size()); end
    for (int i = 0; i < 5 && i < cap_q.size(); i++) begin
      n_checks++;
      if (cap_q[i] !== exp_byte(i, m_seq, s)) begin
        n_errors++; $display("FAIL mrst_byte%0d: got %h expected %h", i, cap_q[i], exp_byte(i, m_seq, s));
      end
    end
    m_seq = (m_seq + 1) % 256;
    tick();
  endtask

  task automatic test_seq_wrap();
    logic [15:0] s;
    bit done;
    int bad;
    do_reset();
    uart_en = 1;
    bad = 0;
    for (int f = 1; f <= 257; f++) begin
      busy_len = 2 + int'($urandom_range(2));
      s = 16'($urandom);
      run_frame(s, 200, done);
      n_checks++;
      if (!done || cap_q.size() != 5) begin
        n_errors++; $display("FAIL wrap_frame%0d: done %0d bytes %0d expected done 1 bytes 5", f, done, cap_q.size());
      end else begin
        for (int i = 0; i < 5; i++) begin
          if (cap_q[i] !== exp_byte(i, m_seq, s)) begin
            bad++;
            $display("FAIL wrap_frame%0d_byte%0d: got %h expected %h", f, i, cap_q[i], exp_byte(i, m_seq, s));
          end
        end
        if (bad != 0) begin
          n_errors++;
          bad = 0;
        end
        if (f == 257) begin
          n_checks++; if (cap_q[1] !== 8'h00) begin n_errors++; $display("FAIL wrap_seq257: got %h expected 00", cap_q[1]); end
        end
      end
      m_seq = (m_seq + 1) % 256;
      tick();
    end
    busy_len = 3;
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_second_frame();
    test_drop_saturate();
    test_start_timeout();
    test_mid_frame_reset();
    test_seq_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tx_frame_packer.md
Name: tx_frame_packer

Overview:
Sits between the averager and the UART transmitter. Accepts one 16-bit averaged sample per handshake and serialises it into a 5-byte frame: SYNC, SEQ, MSB, LSB, CHK. Each byte is issued to the UART through its tx_start/tx_busy handshake. Samples offered while a frame is in flight are dropped and counted.

Parameters:
SYNC_BYTE, 8'hA5, first byte of every frame
START_TIMEOUT, 16, clk cycles to wait for tx_busy to rise after tx_start before flagging an error

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sample_valid  input  1  sample present on sample
sample  input  16  averaged count to transmit
sample_ready  output  1  packer can accept a sample (IDLE only)
tx_busy  input  1  UART transmitter busy
tx_start  output  1  one-cycle pulse requesting transmission of tx_data
tx_data  output  8  byte to transmit; stable from tx_start until tx_busy falls
frame_busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse after the CHK byte completes
tx_error  output  1  sticky; set on START_TIMEOUT expiry, cleared only by reset
drop_count  output  8  saturating count of samples offered while not ready

Behaviour:
- Reset (on a clk edge with reset=1): state IDLE, sample_ready=1, tx_start=0, tx_data=0, frame_busy=0, frame_done=0, tx_error=0, drop_count=0, seq=0, byte index=0. Reset overrides all other activity, including mid-frame; the partial frame is abandoned.
- Accept: when sample_valid=1 and sample_ready=1 on a clk edge, latch sample. Compute CHK = seq ^ sample[15:8] ^ sample[7:0]. Go to LOAD. sample_ready=0 and frame_busy=1 from the next cycle.
- Drop: sample_valid=1 with sample_ready=0 increments drop_count by 1 per cycle, saturating at 255.
- Byte order: idx 0 SYNC_BYTE, 1 seq, 2 sample[15:8], 3 sample[7:0], 4 CHK.
- States:
  - IDLE: wait for accept.
  - LOAD: drive tx_data with byte[idx]. If tx_busy=0, go to START; otherwise stay.
  - START: tx_start=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_HI.
  - WAIT_HI: if tx_busy=1, go to WAIT_LO. If the counter reaches START_TIMEOUT, set tx_error and go to NEXT (the byte is treated as sent, so the packer never hangs).
  - WAIT_LO: if tx_busy=0, go to NEXT.
  - NEXT: if idx=4, pulse frame_done, increment seq (mod 256, wraps 255 to 0), set idx=0, go to IDLE. Otherwise idx+1 and go to LOAD.
- Latency: tx_start for SYNC asserts 2 cycles after the accept edge (LOAD, then START), provided tx_busy=0.
- Back-to-back frames: sample_ready re-asserts the cycle after frame_done. A minimum of one IDLE cycle separates frames.
- tx_data holds its value outside START, and changes only in LOAD.
- Simultaneous sample_valid and reset: reset wins; nothing is latched and drop_count is not incremented.
- Widths: seq is 8 bits. The CHK XOR is 8 bits with no carry.

Test Plan:
1. Reset, then sample 16'h1234 with UART model (busy 3 cycles after each start) -> tx bytes A5,00,12,34,26. One frame_done pulse. seq becomes 01. drop_count=0.
2. Second sample 16'hFFFF -> bytes A5,01,FF,FF,01. Each tx_start is exactly 1 cycle wide. tx_data is stable while busy.
3. Assert sample_valid continuously for 300 cycles during a frame -> drop_count saturates at 255. Only one frame is sent per accept.
4. UART model never raises tx_busy -> tx_error sets 16 cycles after the first tx_start. All 5 starts are still issued. frame_done pulses once.
5. Assert reset during the MSB byte -> next cycle state IDLE, sample_ready=1, seq=0, tx_start=0. The following sample 16'h0001 yields A5,00,00,01,01.
6. Send 256 frames -> the seq byte wraps from FF to 00 on frame 257. CHK matches the XOR of seq, MSB and LSB for every frame.
